// File: rtl/mdu_sequencer_pkg.sv
// Shared op codes, read selects and FSM encoding for the multiply/divide sequencer.
// Imported by the E-stage decode and by mdu_sequencer.
package mdu_sequencer_pkg;

   localparam logic [4:0] MluMult  = 5'd1;
   localparam logic [4:0] MluMultu = 5'd2;
   localparam logic [4:0] MluDiv   = 5'd3;
   localparam logic [4:0] MluDivu  = 5'd4;
   localparam logic [4:0] MluMthi  = 5'd5;
   localparam logic [4:0] MluMtlo  = 5'd6;

   localparam logic [2:0] MluOutHi = 3'd1;
   localparam logic [2:0] MluOutLo = 3'd2;

   typedef enum logic {
      StIdle = 1'b0,
      StRun  = 1'b1
   } mdu_state_e;

   // True for the ops that occupy the unit for several cycles.
   function automatic logic is_md_op(input logic [4:0] op);
      return (op >= MluMult) && (op <= MluDivu);
   endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// E-stage multiply/divide sequencer: owns HI/LO, runs mult/div with fixed latency,
// handles mthi/mtlo and serves mfhi/mflo reads.
module mdu_sequencer
   import mdu_sequencer_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [4:0]  mlu_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  mlu_out,
   input  logic        d_md_use,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] res,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = (MaxCycles > 2) ? $clog2(MaxCycles) : 1;

   mdu_state_e      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]     hi_q, hi_d, lo_q, lo_d;
   logic [31:0]     hi_t_q, hi_t_d, lo_t_q, lo_t_d;

   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic signed [31:0] quo_s, rem_s;
   logic [31:0]        quo_u, rem_u;

   assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign prod_u = {32'd0, A} * {32'd0, B};
   assign quo_s  = $signed(A) / $signed(B);
   assign rem_s  = $signed(A) % $signed(B);
   assign quo_u  = A / B;
   assign rem_u  = A % B;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      hi_t_d  = hi_t_q;
      lo_t_d  = lo_t_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               case (mlu_op)
                  MluMult, MluMultu: begin
                     {hi_t_d, lo_t_d} = (mlu_op == MluMult) ? prod_s : prod_u;
                     cnt_d            = CntW'(MULT_CYCLES - 1);
                     state_d          = StRun;
                  end
                  MluDiv, MluDivu: begin
                     // Divide by zero still occupies the unit but leaves HI/LO untouched.
                     if (B == 32'd0) begin
                        hi_t_d = hi_q;
                        lo_t_d = lo_q;
                     end else if (mlu_op == MluDiv) begin
                        hi_t_d = rem_s;
                        lo_t_d = quo_s;
                     end else begin
                        hi_t_d = rem_u;
                        lo_t_d = quo_u;
                     end
                     cnt_d   = CntW'(DIV_CYCLES - 1);
                     state_d = StRun;
                  end
                  MluMthi: hi_d = A;
                  MluMtlo: lo_d = A;
                  default: ;
               endcase
            end
         end
         StRun: begin
            if (cnt_q == '0) begin
               hi_d    = hi_t_q;
               lo_d    = lo_t_q;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         hi_t_q  <= '0;
         lo_t_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         hi_t_q  <= hi_t_d;
         lo_t_q  <= lo_t_d;
      end
   end

   always_comb begin
      res = 32'd0;
      case (mlu_out)
         MluOutHi: res = hi_q;
         MluOutLo: res = lo_q;
         default:  res = 32'd0;
      endcase
   end

   assign busy      = (state_q == StRun);
   assign stall_req = d_md_use && (busy || (start && is_md_op(mlu_op)));
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: the driver queues expected HI/LO per op,
// the monitor pops and compares whenever an op completes.
module tb_mdu_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [4:0]  mlu_op;
   logic [31:0] A, B;
   logic [2:0]  mlu_out;
   logic        d_md_use;
   logic        busy, stall_req;
   logic [31:0] res, hi, lo;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int          busy_len;
   } exp_t;

   exp_t exp_q[$];

   mdu_sequencer #(
      .MULT_CYCLES(5),
      .DIV_CYCLES (10)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .mlu_op   (mlu_op),
      .A        (A),
      .B        (B),
      .mlu_out  (mlu_out),
      .d_md_use (d_md_use),
      .busy     (busy),
      .stall_req(stall_req),
      .res      (res),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: an op completes when busy falls (mult/div) or one cycle after mthi/mtlo.
   int   busy_cnt    = 0;
   logic prev_busy   = 1'b0;
   logic mt_pending  = 1'b0;
   logic rst_prev    = 1'b0;

   task automatic complete(input int blen);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_completion: got hi=%h lo=%h expected no op", hi, lo);
      end else begin
         e = exp_q.pop_front();
         check({e.name, "_hi"}, hi, e.hi);
         check({e.name, "_lo"}, lo, e.lo);
         check({e.name, "_busy_cycles"}, 32'(blen), 32'(e.busy_len));
      end
   endtask

   always @(negedge clk) begin
      if (start && busy) begin
         n_fail++;
         $display("FAIL start_while_busy: got start=1 busy=1 expected never");
      end
      if (rst_prev) begin
         busy_cnt   = 0;
         mt_pending = 1'b0;
         prev_busy  = 1'b0;
      end else begin
         if (mt_pending) begin
            complete(busy_cnt + int'(busy));
            mt_pending = 1'b0;
         end else if (prev_busy && !busy) begin
            complete(busy_cnt);
            busy_cnt = 0;
         end
         if (busy) busy_cnt++;
         if (start && !busy && (mlu_op == 5'd5 || mlu_op == 5'd6)) mt_pending = 1'b1;
         prev_busy = busy;
      end
      rst_prev = reset;
   end

   task automatic issue(input string nm, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_busy,
                        input logic [31:0] old_hi, output int stalls);
      bit done = 0;
      stalls = 0;
      @(posedge clk) #1;
      start  = 1'b1;
      mlu_op = op;
      A      = a;
      B      = b;
      exp_q.push_back('{nm, exp_hi, exp_lo, exp_busy});
      @(negedge clk);
      stalls += int'(stall_req);
      @(posedge clk) #1;
      start  = 1'b0;
      mlu_op = 5'd0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         stalls += int'(stall_req);
         if (i == 0 && exp_busy > 0) check({nm, "_res_during_run"}, res, old_hi);
         if (!busy) begin
            done = 1;
            break;
         end
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: got busy=1 after 40 cycles expected idle", nm);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before 100000");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      reset    = 1'b1;
      start    = 1'b0;
      mlu_op   = 5'd0;
      A        = '0;
      B        = '0;
      mlu_out  = 3'd1;
      d_md_use = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      check("reset_stall", 32'(stall_req), 32'd0);
      check("reset_res", res, 32'd0);

      issue("mult", 5'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 32'd0, st);
      issue("multu", 5'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5,
            32'hFFFF_FFFF, st);
      issue("div", 5'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10,
            32'h0000_0001, st);
      issue("divu", 5'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10, 32'hFFFF_FFFF, st);
      issue("mthi", 5'd5, 32'd1234, 32'd0, 32'd1234, 32'd3, 0, 32'd1, st);

      mlu_out = 3'd1; #1 check("mfhi_res", res, 32'd1234);
      mlu_out = 3'd2; #1 check("mflo_res", res, 32'd3);
      mlu_out = 3'd0; #1 check("res_sel0", res, 32'd0);
      mlu_out = 3'd3; #1 check("res_sel3", res, 32'd0);
      mlu_out = 3'd1;

      issue("mtlo", 5'd6, 32'd55, 32'd0, 32'd1234, 32'd55, 0, 32'd1234, st);
      issue("div_by_zero", 5'd3, 32'd100, 32'd0, 32'd1234, 32'd55, 10, 32'd1234, st);

      // Undefined op code must leave everything alone and never request a stall.
      @(posedge clk) #1;
      d_md_use = 1'b1;
      start    = 1'b1;
      mlu_op   = 5'd7;
      A        = 32'd999;
      @(negedge clk);
      check("op7_stall", 32'(stall_req), 32'd0);
      @(posedge clk) #1;
      start  = 1'b0;
      mlu_op = 5'd0;
      @(negedge clk);
      check("op7_busy", 32'(busy), 32'd0);
      check("op7_hi", hi, 32'd1234);
      check("op7_lo", lo, 32'd55);

      issue("mult_stall", 5'd1, 32'h0001_0001, 32'h0003_0000, 32'h0000_0003, 32'h0003_0000, 5,
            32'd1234, st);
      check("stall_cycles", 32'(st), 32'd6);

      // Reset three cycles into a mult aborts it and clears HI/LO.
      @(posedge clk) #1;
      start  = 1'b1;
      mlu_op = 5'd1;
      A      = 32'd5;
      B      = 32'd6;
      @(posedge clk) #1;
      start  = 1'b0;
      mlu_op = 5'd0;
      @(posedge clk) #1;
      @(posedge clk) #1;
      reset = 1'b1;
      @(posedge clk) #1;
      reset = 1'b0;
      @(negedge clk);
      check("midop_reset_busy", 32'(busy), 32'd0);
      check("midop_reset_hi", hi, 32'd0);
      check("midop_reset_lo", lo, 32'd0);
      check("midop_reset_stall", 32'(stall_req), 32'd0);
      repeat (12) @(negedge clk);
      check("aborted_hi", hi, 32'd0);
      check("aborted_lo", lo, 32'd0);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      d_md_use = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
